stream_unpacker: RTL and testbench
==================================

Name: stream_unpacker

Overview:
Takes one wide word of Ratio packed samples on a valid/ready slave stream and emits the samples one at a time, LSB lane first, on a valid/ready master stream of sample width. It is the read-side counterpart of the packing/enable-register path. Packed words loaded on enable are unpacked sample by sample for the DWT/coefficient pipelines, and frame framing (last) is carried through to the final sample.

Parameters:
Width, 16, bits per sample
Ratio, 4, samples per packed input word (legal range 1..16)
ResetVal, 0, reset value of m_data_o

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
s_valid_i  input  1  packed word valid
s_ready_o  output  1  unpacker can accept a word this cycle
s_data_i  input  Width*Ratio  packed word; lane k = bits [k*Width +: Width]
s_last_i  input  1  word is last of frame
m_valid_o  output  1  sample valid
m_ready_i  input  1  downstream accepts sample
m_data_o  output  Width  current sample
m_lane_o  output  LaneW  index of current lane; LaneW = max(1, clog2(Ratio))
m_last_o  output  1  high only on lane Ratio-1 of a word received with s_last_i=1

Behaviour:
- Reset values: state EMPTY, m_valid_o=0, m_data_o=ResetVal, m_lane_o=0, m_last_o=0, word register=0, last flag=0. All values apply asynchronously on rst_i rise. s_ready_o=0 while rst_i=1.
- State machine has two states, EMPTY and EMIT.
  - EMPTY: s_ready_o=1. On s_valid_i: capture s_data_i and s_last_i, set lane=0, go to EMIT.
  - EMIT: m_valid_o=1, m_data_o=lane[lane_cnt], m_lane_o=lane_cnt, m_last_o=last_flag && (lane_cnt==Ratio-1).
    - On m_ready_i with lane_cnt<Ratio-1: lane_cnt+1.
    - On m_ready_i with lane_cnt==Ratio-1 and s_valid_i: load the new word, set lane_cnt=0, stay in EMIT. This is the zero-bubble case.
    - On m_ready_i with lane_cnt==Ratio-1 and !s_valid_i: go to EMPTY.
- s_ready_o = (state==EMPTY) || (m_ready_i && lane_cnt==Ratio-1). This is the only combinational path from m_ready_i to s_ready_o. It is required for full throughput.
- Latency: first sample is valid the cycle after the word handshake. Sustained throughput is one sample per cycle with no bubble between words.
- Output stability: while m_valid_o && !m_ready_i, m_data_o, m_lane_o and m_last_o hold constant. The word register is not written.
- Sample data is registered, not muxed from s_data_i. m_data_o is driven from the word register via the lane mux, and the lane mux depends on registered state only.
- Ratio=1: every handshake is a word boundary. The block behaves as a one-entry register slice: s_ready_o = empty || m_ready_i.
- lane_cnt wraps only via reload or EMPTY and never counts past Ratio-1.
- Reset mid-word discards the remaining lanes with no partial output afterwards. After deassertion the block is in EMPTY with s_ready_o=1 on the first clock.
- s_valid_i while s_ready_o=0 is legal: the upstream holds the word, and the block does not sample it.

Decomposition:
- Shared package jpeg2k_stream_pkg holds:
  - the LaneW calculation function (max(1,$clog2(Ratio)))
  - the state enum typedef (EMPTY, EMIT)
  - the lane slice helper function.
- Dffenr is not reused: its reset is synchronous and this block requires asynchronous reset.
- One natural sub-module is stream_lane_mux, a combinational Ratio:1 Width-bit selector, shared with a future packer.
- Target size: ~150 lines.

Test Plan:
- Reset: assert rst_i mid-clock with s_valid_i=1 and m_ready_i=1. Required: m_valid_o=0 and m_data_o=ResetVal immediately, without waiting for a clock edge. s_ready_o=1 on the first cycle after release.
- Single word: Width=16, Ratio=4, word 0x4444_3333_2222_1111 with s_last_i=1, m_ready_i=1. Required: samples 0x1111, 0x2222, 0x3333, 0x4444 on four consecutive cycles, m_lane_o=0..3, m_last_o=1 only on 0x4444, then EMPTY.
- Back-to-back words: s_valid_i=1 continuously with words A then B. Required: 8 samples on 8 consecutive cycles, s_ready_o pulses high on the lane-3 cycle of A, no bubble between A3 and B0.
- Backpressure: m_ready_i toggles 1,0,0,1,... Required: m_data_o is stable on every stalled cycle, no lane is skipped or duplicated, and the total is 4 samples per word.
- Stall on last lane: lane 3 is presented, m_ready_i=0 for 5 cycles, s_valid_i=1. Required: s_ready_o=0 for all 5 cycles and the next word is loaded on the cycle m_ready_i returns.
- Ratio=1, Width=8: stream 0x01..0x10 with random m_ready_i. Required: output equals input in order, m_last_o mirrors s_last_i, and a scoreboard reports no loss.

Source files
------------

// File: rtl/jpeg2k_stream_pkg.sv
// rtl/jpeg2k_stream_pkg.sv - shared types and helpers for the packed-sample stream blocks
package jpeg2k_stream_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } unpack_state_e;

    // Lane index width; a single-lane word still needs a one-bit index.
    function automatic int lane_w(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/stream_lane_mux.sv
// rtl/stream_lane_mux.sv - combinational Ratio:1 selector of Width-bit lanes
module stream_lane_mux
    import jpeg2k_stream_pkg::*;
#(
    parameter int Width = 16,
    parameter int Ratio = 4,
    parameter int LaneW = lane_w(Ratio)
) (
    input  logic [Width*Ratio-1:0] lanes,
    input  logic [LaneW-1:0]       sel,
    output logic [Width-1:0]       sample
);

    always_comb begin
        sample = '0;
        for (int k = 0; k < Ratio; k++) begin
            if (sel == LaneW'(k)) begin
                sample = lanes[lane_lsb(k, Width) +: Width];
            end
        end
    end

endmodule

// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - unpacks one wide word into Ratio samples, LSB lane first
module stream_unpacker
    import jpeg2k_stream_pkg::*;
#(
    parameter int               Width    = 16,
    parameter int               Ratio    = 4,
    parameter logic [Width-1:0] ResetVal = '0,
    localparam int              LaneW    = lane_w(Ratio)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [Width*Ratio-1:0] s_data_i,
    input  logic                   s_last_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [Width-1:0]       m_data_o,
    output logic [LaneW-1:0]       m_lane_o,
    output logic                   m_last_o
);

    localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);

    unpack_state_e          state_q, state_d;
    logic [LaneW-1:0]       lane_q, lane_d;
    logic [Width*Ratio-1:0] word_q, word_d;
    logic                   last_q, last_d;
    logic [Width-1:0]       sample;
    logic                   at_last_lane;
    logic                   emitting;

    assign emitting     = (state_q == EMIT);
    assign at_last_lane = (lane_q == LastLane);

    // The m_ready_i term lets a new word land in the same cycle the last lane leaves.
    assign s_ready_o = !rst_i &&
                       ((state_q == EMPTY) || (emitting && m_ready_i && at_last_lane));

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        last_d  = last_q;
        case (state_q)
            EMPTY: begin
                if (s_valid_i) begin
                    word_d  = s_data_i;
                    last_d  = s_last_i;
                    lane_d  = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (m_ready_i) begin
                    if (!at_last_lane) begin
                        lane_d = lane_q + LaneW'(1);
                    end else if (s_valid_i) begin
                        word_d = s_data_i;
                        last_d = s_last_i;
                        lane_d = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            lane_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    stream_lane_mux #(
        .Width (Width),
        .Ratio (Ratio),
        .LaneW (LaneW)
    ) u_lane_mux (
        .lanes  (word_q),
        .sel    (lane_q),
        .sample (sample)
    );

    // Outputs are gated by registered state so reset clears them without a clock.
    assign m_valid_o = emitting;
    assign m_data_o  = emitting ? sample : ResetVal;
    assign m_lane_o  = emitting ? lane_q : '0;
    assign m_last_o  = emitting && last_q && at_last_lane;

endmodule

// File: tb/tb_stream_unpacker.sv
// tb/tb_stream_unpacker.sv - randomized and directed bench for stream_unpacker against a sample-queue model
module tb_stream_unpacker;

    localparam int          WA   = 16;
    localparam int          RA   = 4;
    localparam logic [15:0] RV_A = 16'hA5A5;
    localparam int          WB   = 8;
    localparam logic [7:0]  RV_B = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_s_valid = 1'b0, a_s_ready, a_s_last = 1'b0;
    logic [63:0] a_s_data = '0;
    logic        a_m_valid, a_m_ready = 1'b0, a_m_last;
    logic [15:0] a_m_data;
    logic [1:0]  a_m_lane;

    logic        b_s_valid = 1'b0, b_s_ready, b_s_last = 1'b0;
    logic [7:0]  b_s_data = '0;
    logic        b_m_valid, b_m_ready = 1'b0, b_m_last;
    logic [7:0]  b_m_data;
    logic [0:0]  b_m_lane;

    stream_unpacker #(.Width(WA), .Ratio(RA), .ResetVal(RV_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(a_s_valid), .s_ready_o(a_s_ready), .s_data_i(a_s_data), .s_last_i(a_s_last),
        .m_valid_o(a_m_valid), .m_ready_i(a_m_ready), .m_data_o(a_m_data),
        .m_lane_o(a_m_lane), .m_last_o(a_m_last)
    );

    stream_unpacker #(.Width(WB), .Ratio(1), .ResetVal(RV_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .s_data_i(b_s_data), .s_last_i(b_s_last),
        .m_valid_o(b_m_valid), .m_ready_i(b_m_ready), .m_data_o(b_m_data),
        .m_lane_o(b_m_lane), .m_last_o(b_m_last)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  lane;
        logic        last;
    } samp_a_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } samp_b_t;

    samp_a_t qa[$];
    samp_b_t qb[$];
    int      tests = 0;
    int      fails = 0;
    logic    acc_a, acc_b;
    int      mode_a = 0, mode_b = 0, bp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply ready policy, compare at negedge against the model, then advance it.
    task automatic cycle();
        logic    rdy_a, rdy_b;
        samp_a_t ea;
        samp_a_t eb_a;
        samp_b_t eb;
        case (mode_a)
            0: a_m_ready = 1'b1;
            1: a_m_ready = (bp_cnt % 3 == 0);
            2: a_m_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
        case (mode_b)
            0: b_m_ready = 1'b1;
            2: b_m_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
        bp_cnt++;
        @(negedge clk);
        rdy_a = !rst && (qa.size() == 0 || (a_m_ready && qa.size() == 1));
        check("a_s_ready", 64'(a_s_ready), 64'(rdy_a));
        check("a_m_valid", 64'(a_m_valid), 64'(!rst && qa.size() != 0));
        if (qa.size() != 0 && a_m_valid) begin
            ea = qa[0];
            check("a_m_data", 64'(a_m_data), 64'(ea.data));
            check("a_m_lane", 64'(a_m_lane), 64'(ea.lane));
            check("a_m_last", 64'(a_m_last), 64'(ea.last));
        end
        acc_a = a_s_valid && rdy_a;
        if (!rst && qa.size() != 0 && a_m_ready) void'(qa.pop_front());
        if (acc_a) begin
            for (int k = 0; k < RA; k++) begin
                eb_a.data = a_s_data[k*WA +: WA];
                eb_a.lane = k[1:0];
                eb_a.last = a_s_last && (k == RA - 1);
                qa.push_back(eb_a);
            end
        end

        rdy_b = !rst && (qb.size() == 0 || b_m_ready);
        check("b_s_ready", 64'(b_s_ready), 64'(rdy_b));
        check("b_m_valid", 64'(b_m_valid), 64'(!rst && qb.size() != 0));
        if (qb.size() != 0 && b_m_valid) begin
            eb = qb[0];
            check("b_m_data", 64'(b_m_data), 64'(eb.data));
            check("b_m_lane", 64'(b_m_lane), 64'd0);
            check("b_m_last", 64'(b_m_last), 64'(eb.last));
        end
        acc_b = b_s_valid && rdy_b;
        if (!rst && qb.size() != 0 && b_m_ready) void'(qb.pop_front());
        if (acc_b) begin
            eb.data = b_s_data;
            eb.last = b_s_last;
            qb.push_back(eb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [63:0] w, input logic l);
        int n = 0;
        a_s_valid = 1'b1;
        a_s_data  = w;
        a_s_last  = l;
        do begin
            cycle();
            n++;
        end while (!acc_a && n < 64);
        check("a_send_accepted", 64'(acc_a), 64'd1);
        a_s_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic l);
        int n = 0;
        b_s_valid = 1'b1;
        b_s_data  = d;
        b_s_last  = l;
        do begin
            cycle();
            n++;
        end while (!acc_b && n < 64);
        check("b_send_accepted", 64'(acc_b), 64'd1);
        b_s_valid = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_a_m_valid", 64'(a_m_valid), 64'd0);
        check("rst_a_m_data", 64'(a_m_data), 64'(RV_A));
        check("rst_a_m_lane", 64'(a_m_lane), 64'd0);
        check("rst_a_m_last", 64'(a_m_last), 64'd0);
        check("rst_a_s_ready", 64'(a_s_ready), 64'd0);
        check("rst_b_m_data", 64'(b_m_data), 64'(RV_B));
        @(posedge clk);
        #1 rst = 1'b0;

        // single word with last
        mode_a = 0;
        send_a(64'h4444_3333_2222_1111, 1'b1);
        repeat (6) cycle();

        // back-to-back words with valid held high
        a_s_valid = 1'b1;
        send_a(64'hA3A3_A2A2_A1A1_A0A0, 1'b0);
        a_s_valid = 1'b1;
        send_a(64'hB3B3_B2B2_B1B1_B0B0, 1'b1);
        repeat (6) cycle();

        // backpressure pattern 1,0,0
        mode_a = 1;
        bp_cnt = 0;
        for (int i = 0; i < 3; i++) send_a({$urandom, $urandom}, 1'(i == 2));
        repeat (16) cycle();

        // stall on last lane with next word waiting
        mode_a = 3;
        a_m_ready = 1'b1;
        send_a(64'hC3C3_C2C2_C1C1_C0C0, 1'b0);
        a_s_valid = 1'b1;
        a_s_data  = 64'hD3D3_D2D2_D1D1_D0D0;
        a_s_last  = 1'b1;
        repeat (3) cycle();
        a_m_ready = 1'b0;
        repeat (5) cycle();
        check("stall_lane3_held", 64'(qa.size()), 64'd1);
        a_m_ready = 1'b1;
        cycle();
        check("stall_reload", 64'(acc_a), 64'd1);
        a_s_valid = 1'b0;
        repeat (6) cycle();

        // randomized words, random readiness and gaps
        mode_a = 2;
        for (int i = 0; i < 20; i++) begin
            send_a({$urandom, $urandom}, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) cycle();
        end
        mode_a = 0;
        repeat (8) cycle();
        check("a_drained", 64'(qa.size()), 64'd0);

        // Ratio=1 stream 0x01..0x10
        mode_b = 2;
        for (int i = 1; i <= 16; i++) send_b(8'(i), 1'(i % 4 == 0));
        mode_b = 0;
        repeat (4) cycle();
        check("b_drained", 64'(qb.size()), 64'd0);

        // reset in the middle of a word
        a_s_valid = 1'b1;
        b_s_valid = 1'b1;
        send_a(64'hE3E3_E2E2_E1E1_E0E0, 1'b1);
        a_s_valid = 1'b1;
        b_s_valid = 1'b1;
        cycle();
        #2 rst = 1'b1;
        #1;
        check("midrst_a_m_valid", 64'(a_m_valid), 64'd0);
        check("midrst_a_m_data", 64'(a_m_data), 64'(RV_A));
        check("midrst_a_m_last", 64'(a_m_last), 64'd0);
        check("midrst_a_s_ready", 64'(a_s_ready), 64'd0);
        check("midrst_b_m_valid", 64'(b_m_valid), 64'd0);
        check("midrst_b_m_data", 64'(b_m_data), 64'(RV_B));
        qa.delete();
        qb.delete();
        a_s_valid = 1'b0;
        b_s_valid = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        check("post_rst_a_ready", 64'(a_s_ready), 64'd1);
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
